// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared constants and helpers for the seven-segment display
//               scan logic (segment encoding, bit order, index widths).
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // All segments off (segments are active-low on the board).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment bit positions inside the 7-bit segment vector.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Width needed to index n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/BCD_to_sevenSeg.sv
`default_nettype none
// ============================================================================
// Module      : BCD_to_sevenSeg
// Description : Combinational hex nibble to active-low seven-segment decoder.
//               Output bit 6 drives segment a, bit 0 drives segment g.
// Revision    : 1.0 - initial release
// ============================================================================
module BCD_to_sevenSeg
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Lookup of the lit-segment pattern for each hex value (0 = segment on).
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_mux
// Description : Time-multiplexed scan driver for a common-anode seven-segment
//               display. One digit is shown per slot, with a short all-dark
//               gap at the start of each slot to avoid ghosting. All pin
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module display_mux
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100_000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [6:0]            segments,
    output logic                  dp
);

    localparam int IDX_W = idx_width(N_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]          segments_q, segments_d;
    logic                dp_q, dp_d;

    logic [3:0]          w_nib [N_DIGITS];
    logic [N_DIGITS:1]   w_zero_from;   // digits i..N_DIGITS-1 all zero
    logic [N_DIGITS-1:0] w_blanked;
    logic [6:0]          w_dec_seg;
    logic                w_in_gap;

    // The top-of-chain entry stands for "no digits above the MSD".
    assign w_zero_from[N_DIGITS] = 1'b1;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        assign w_nib[i] = digits_in[4*i +: 4];
        if (i == 0) begin : g_lsd
            // The rightmost digit always shows, so a zero value reads "0".
            assign w_blanked[i] = ~digit_en[i];
        end else begin : g_upper
            assign w_zero_from[i] = (w_nib[i] == 4'h0) && w_zero_from[i+1];
            assign w_blanked[i]   = ~digit_en[i] | (blank_lz & w_zero_from[i]);
        end
    end

    if (BLANK_CYC > 0) begin : g_gap
        assign w_in_gap = (cnt_q < CNT_W'(BLANK_CYC));
    end else begin : g_no_gap
        assign w_in_gap = 1'b0;
    end

    BCD_to_sevenSeg u_dec (
        .bcd_i (w_nib[idx_q]),
        .seg_o (w_dec_seg)
    );

    // Next-state for slot counter / digit index and the pin values.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        anodes_d   = '1;
        segments_d = SEG_BLANK;
        dp_d       = 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (!w_in_gap && !w_blanked[idx_q]) begin
            anodes_d[idx_q] = 1'b0;
            segments_d      = w_dec_seg;
            dp_d            = ~dp_in[idx_q];
        end
    end

    // State and pin registers; reset forces everything dark at digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            anodes_q   <= '1;
            segments_q <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
        end
    end

    assign anodes   = anodes_q;
    assign segments = segments_q;
    assign dp       = dp_q;

endmodule
`default_nettype wire

// File: doc/display_mux.md
# display_mux

Time-multiplexed driver for the board's common-anode seven-segment display. It scans N_DIGITS hex digits and presents one digit at a time to the combinational hex-to-seven-segment decoder. It registers the decoded segments, the decimal point and the active-low anode selects for the display pins. It sits between the datapath registers that hold the values to show and the FPGA display pins.

## Interface
Parameters:
- N_DIGITS, 8, number of digits scanned (≥2).
- REFRESH_DIV, 100_000, clock cycles per digit slot (1 kHz slot rate at 100 MHz).
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must satisfy 0 ≤ BLANK_CYC < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*N_DIGITS  digit i = digits_in[4i+3:4i]; digit 0 is least significant (rightmost).
- digit_en  in  N_DIGITS  1 = digit i may light; 0 = digit i forced blank.
- dp_in  in  N_DIGITS  1 = decimal point of digit i lit.
- blank_lz  in  1  1 = suppress leading zeros.
- anodes  out  N_DIGITS  active-low digit selects; at most one bit low at any time.
- segments  out  7  active-low segments, bit 6 = a … bit 0 = g.
- dp  out  1  active-low decimal point.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit index idx advances: idx = (idx+1) mod N_DIGITS.
  - Scan order is 0,1,…,N_DIGITS-1,0,…
- Digit i is *blanked* in any of these cases:
  - digit_en[i]=0;
  - blank_lz=1, i>0, and digits i..N_DIGITS-1 are all 4'h0.
- Digit 0 is never blanked by blank_lz, so the value 0 shows as a single "0".
- Output registers update on every clock edge where reset is low, from the pre-edge idx, cnt and current inputs:
  - if cnt < BLANK_CYC, or digit idx is blanked: anodes all 1, segments 7'b1111111, dp 1;
  - otherwise: anodes = ~(1<<idx), segments = decoder(digit idx), dp = ~dp_in[idx].
- Decoder values 0–F follow the team encoding. Examples: 0→7'b0000001, 8→7'b0000000, A→7'b0001000, F→7'b0111000.
- No handshake: inputs are level-sampled every cycle, with no requirement to be stable across a scan.
- Reset:
  - cnt=0, idx=0, anodes all 1, segments 7'b1111111, dp=1.
  - Reset asserted mid-scan takes effect at that edge, regardless of cnt or idx.

## Timing
- Output latency: 1 cycle from any input change to the pins.
- After reset deasserts, at edge k (k=1 is the first edge with reset low):
  - digit 0 lights on edge BLANK_CYC+1;
  - digit 0 stays lit through edge REFRESH_DIV;
  - edges REFRESH_DIV+1 .. REFRESH_DIV+BLANK_CYC are dark;
  - digit 1 then lights.
- Each digit is lit for REFRESH_DIV−BLANK_CYC cycles per frame. Frame period = N_DIGITS·REFRESH_DIV cycles.
- BLANK_CYC=0: no dark gap; anodes move directly from digit i to digit i+1 on one edge.
- idx wraps from N_DIGITS-1 to 0 with no extra cycle.
- Glitch-free: all pin outputs come straight from flops.

## Structure
- Shared package disp_pkg holds:
  - SEG_BLANK = 7'b1111111;
  - the segment bit-order constants (a..g → 6..0);
  - an idx-width helper, $clog2(N_DIGITS) with a minimum of 1.
- One sub-module: the existing combinational decoder BCD_to_sevenSeg, instantiated once and fed the selected nibble.
- The counter, index, leading-zero logic and output registers live in display_mux.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
- Reset:
  - hold reset 3 cycles with arbitrary inputs → anodes=4'b1111, segments=7'b1111111, dp=1 throughout;
  - reset low → edges 2–4 give anodes=4'b1110.
- Full scan:
  - digits_in=16'h8A3F, digit_en=4'hF, dp_in=0, blank_lz=0;
  - lit slots show, in order: 4'b1110/F (7'b0111000), 4'b1101/3 (7'b0000110), 4'b1011/A (7'b0001000), 4'b0111/8 (7'b0000000);
  - one dark cycle (anodes=4'b1111) before each slot;
  - sequence repeats every 16 cycles.
- Leading zeros:
  - digits_in=16'h0050, blank_lz=1 → digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0;
  - digits_in=16'h0000 → only digit 0 lit, showing 7'b0000001.
- Enable/dp:
  - digit_en=4'b1011, dp_in=4'b0010 → slot 2 fully dark;
  - dp=0 only while anodes=4'b1101.
- Mid-scan reset and live update:
  - assert reset during slot 2 → reset values on the next edge, scan restarts at digit 0;
  - separately, change digits_in mid-slot → segments change exactly 1 cycle later.
